drop_sequencer: RTL and testbench

- Turn controller for the Connect-Four board.
- Accepts a column request from the player to move and rejects it if the column is illegal or full.
- Animates the falling piece one row per display tick, then commits it to the piled-count array and toggles the player.
- Sits between the input/keypad logic and the ST7789 renderer and win checker; it is the sole writer of the piled-count array.

---
 rtl/drop_sequencer_if.sv | 37 +++
 rtl/drop_sequencer.sv | 143 ++++++++++++++
 tb/tb_drop_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/drop_sequencer_if.sv
// Request/animation/commit bundle between the keypad front end, the drop
// sequencer and its consumers (renderer, win checker).
interface drop_sequencer_if #(
    parameter int COL_COUNT = 7,
    parameter int ROW_SIZE  = 3,
    parameter int COL_SIZE  = 3
);
    logic                          i_req;
    logic [COL_SIZE-1:0]           i_col;
    logic                          i_tick;
    logic                          o_ack;
    logic                          o_nack;
    logic                          o_busy;
    logic                          o_player;
    logic                          o_fall_valid;
    logic [COL_SIZE-1:0]           o_fall_col;
    logic [ROW_SIZE-1:0]           o_fall_row;
    logic [COL_COUNT*ROW_SIZE-1:0] o_piled_count_array;
    logic                          o_commit;
    logic [COL_SIZE-1:0]           o_commit_col;
    logic [ROW_SIZE-1:0]           o_commit_row;
    logic                          o_board_full;

    modport master (
        output i_req, i_col, i_tick,
        input  o_ack, o_nack, o_busy, o_player, o_fall_valid, o_fall_col,
               o_fall_row, o_piled_count_array, o_commit, o_commit_col,
               o_commit_row, o_board_full
    );

    modport slave (
        input  i_req, i_col, i_tick,
        output o_ack, o_nack, o_busy, o_player, o_fall_valid, o_fall_col,
               o_fall_row, o_piled_count_array, o_commit, o_commit_col,
               o_commit_row, o_board_full
    );
endinterface

// File: rtl/drop_sequencer.sv
// Connect-Four turn controller: validates a column request, animates the piece
// down one row per tick, then commits it to the pile counts and swaps player.
module drop_sequencer #(
    parameter int COL_COUNT = 7,
    parameter int ROW_COUNT = 6,
    parameter int ROW_SIZE  = 3,
    parameter int COL_SIZE  = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    drop_sequencer_if.slave bus
);
    localparam int TOTAL_W = $clog2(COL_COUNT * ROW_COUNT + 1);
    localparam logic [TOTAL_W-1:0]  CELLS    = TOTAL_W'(COL_COUNT * ROW_COUNT);
    localparam logic [ROW_SIZE-1:0] ROW_FULL = ROW_SIZE'(ROW_COUNT);
    localparam logic [ROW_SIZE-1:0] ROW_TOP  = ROW_SIZE'(ROW_COUNT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FALL   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_FULL   = 2'd3;

    logic [1:0]          state_reg;
    logic [ROW_SIZE-1:0] count_reg [COL_COUNT];
    logic [TOTAL_W-1:0]  total_reg;
    logic [COL_SIZE-1:0] col_reg;
    logic [ROW_SIZE-1:0] target_reg;
    logic [ROW_SIZE-1:0] row_reg;
    logic                ack_reg;
    logic                nack_reg;
    logic                busy_reg;
    logic                player_reg;
    logic                fall_valid_reg;
    logic                commit_reg;
    logic [COL_SIZE-1:0] commit_col_reg;
    logic [ROW_SIZE-1:0] commit_row_reg;
    logic                board_full_reg;

    logic [ROW_SIZE-1:0] req_count;
    logic                req_legal;

    // Out-of-range columns select nothing, so the range test alone rejects them.
    always_comb begin
        req_count = '0;
        for (int c = 0; c < COL_COUNT; c++) begin
            if (bus.i_col == COL_SIZE'(c)) begin
                req_count = count_reg[c];
            end
        end
        req_legal = ({1'b0, bus.i_col} < (COL_SIZE + 1)'(COL_COUNT)) &&
                    (req_count != ROW_FULL);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            for (int c = 0; c < COL_COUNT; c++) begin
                count_reg[c] <= '0;
            end
            total_reg      <= '0;
            col_reg        <= '0;
            target_reg     <= '0;
            row_reg        <= '0;
            ack_reg        <= 1'b0;
            nack_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            player_reg     <= 1'b0;
            fall_valid_reg <= 1'b0;
            commit_reg     <= 1'b0;
            commit_col_reg <= '0;
            commit_row_reg <= '0;
            board_full_reg <= 1'b0;
        end else begin
            ack_reg    <= 1'b0;
            nack_reg   <= 1'b0;
            commit_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        if (!req_legal) begin
                            nack_reg <= 1'b1;
                        end else begin
                            col_reg        <= bus.i_col;
                            target_reg     <= req_count;
                            row_reg        <= ROW_TOP;
                            ack_reg        <= 1'b1;
                            fall_valid_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                            state_reg      <= ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (bus.i_tick) begin
                        if (row_reg == target_reg) begin
                            // Commit is applied on entry so o_commit coincides with COMMIT.
                            fall_valid_reg     <= 1'b0;
                            count_reg[col_reg] <= count_reg[col_reg] + 1'b1;
                            total_reg          <= total_reg + 1'b1;
                            player_reg         <= ~player_reg;
                            commit_reg         <= 1'b1;
                            commit_col_reg     <= col_reg;
                            commit_row_reg     <= target_reg;
                            state_reg          <= ST_COMMIT;
                        end else begin
                            row_reg <= row_reg - 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    busy_reg <= 1'b0;
                    if (total_reg == CELLS) begin
                        board_full_reg <= 1'b1;
                        state_reg      <= ST_FULL;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FULL: begin
                    if (bus.i_req) begin
                        nack_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < COL_COUNT; gi++) begin : g_pack
        assign bus.o_piled_count_array[gi*ROW_SIZE +: ROW_SIZE] = count_reg[gi];
    end

    assign bus.o_ack        = ack_reg;
    assign bus.o_nack       = nack_reg;
    assign bus.o_busy       = busy_reg;
    assign bus.o_player     = player_reg;
    assign bus.o_fall_valid = fall_valid_reg;
    assign bus.o_fall_col   = col_reg;
    assign bus.o_fall_row   = row_reg;
    assign bus.o_commit     = commit_reg;
    assign bus.o_commit_col = commit_col_reg;
    assign bus.o_commit_row = commit_row_reg;
    assign bus.o_board_full = board_full_reg;
endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer: single drop animation, rejects, ignored
// requests while falling, a full 42-piece game and an asynchronous reset mid-fall.
module tb_drop_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_counts [7];
    logic exp_player;

    drop_sequencer_if #(.COL_COUNT(7), .ROW_SIZE(3), .COL_SIZE(3)) bus ();

    drop_sequencer #(
        .COL_COUNT(7), .ROW_COUNT(6), .ROW_SIZE(3), .COL_SIZE(3)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic req, input logic [2:0] col, input logic tick);
        bus.i_req  = req;
        bus.i_col  = col;
        bus.i_tick = tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] packed_model();
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < 7; c++) begin
            v = v | (32'(exp_counts[c]) << (3 * c));
        end
        return v;
    endfunction

    // One legal drop with ticks every cycle; returns to IDLE/FULL afterwards.
    task automatic drop(input int c);
        int   tgt;
        int   nticks;
        logic seen;
        tgt    = exp_counts[c];
        nticks = 0;
        seen   = 1'b0;
        step(1'b1, 3'(c), 1'b0);
        chk("drop_ack", bus.o_ack, 1);
        chk("drop_fall_row_top", bus.o_fall_row, 5);
        for (int k = 0; k < 12 && !seen; k++) begin
            step(1'b0, 3'd0, 1'b1);
            nticks++;
            seen = bus.o_commit;
        end
        chk("drop_commit_seen", seen, 1);
        chk("drop_tick_count", nticks, 6 - tgt);
        chk("drop_commit_col", bus.o_commit_col, c);
        chk("drop_commit_row", bus.o_commit_row, tgt);
        exp_counts[c]++;
        exp_player = ~exp_player;
        chk("drop_array", bus.o_piled_count_array, packed_model());
        chk("drop_player", bus.o_player, exp_player);
        step(1'b0, 3'd0, 1'b0);
        chk("drop_idle_busy", bus.o_busy, 0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_player = 1'b0;
        for (int c = 0; c < 7; c++) exp_counts[c] = 0;
        rst_n      = 1'b0;
        bus.i_req  = 1'b0;
        bus.i_col  = 3'd0;
        bus.i_tick = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", bus.o_ack, 0);
        chk("rst_nack", bus.o_nack, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_player", bus.o_player, 0);
        chk("rst_fall", {bus.o_fall_valid, bus.o_fall_col, bus.o_fall_row}, 0);
        chk("rst_array", bus.o_piled_count_array, 0);
        chk("rst_commit", {bus.o_commit, bus.o_commit_col, bus.o_commit_row}, 0);
        chk("rst_full", bus.o_board_full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, 1'b0);

        // Illegal column 7 on empty board
        step(1'b1, 3'd7, 1'b0);
        chk("col7_nack", bus.o_nack, 1);
        chk("col7_ack", bus.o_ack, 0);
        step(1'b0, 3'd0, 1'b0);
        chk("col7_nack_pulse", bus.o_nack, 0);
        chk("col7_array", bus.o_piled_count_array, 0);

        // Tick in IDLE is ignored
        step(1'b0, 3'd0, 1'b1);
        chk("idle_tick_busy", bus.o_busy, 0);

        // Column 3 with simultaneous tick; then requests for col 1 held during FALL
        step(1'b1, 3'd3, 1'b1);
        chk("c3_ack", bus.o_ack, 1);
        chk("c3_busy", bus.o_busy, 1);
        chk("c3_fall_valid", bus.o_fall_valid, 1);
        chk("c3_fall_col", bus.o_fall_col, 3);
        chk("c3_fall_row_first", bus.o_fall_row, 5);
        for (int r = 4; r >= 0; r--) begin
            step(1'b1, 3'd1, 1'b1);
            chk("c3_fall_row", bus.o_fall_row, r);
            chk("c3_no_handshake", {bus.o_ack, bus.o_nack}, 0);
        end
        step(1'b1, 3'd1, 1'b1);
        chk("c3_commit", bus.o_commit, 1);
        chk("c3_commit_col", bus.o_commit_col, 3);
        chk("c3_commit_row", bus.o_commit_row, 0);
        chk("c3_fall_drop", bus.o_fall_valid, 0);
        chk("c3_busy_commit", bus.o_busy, 1);
        chk("c3_array", bus.o_piled_count_array, 21'o0001000);
        chk("c3_player", bus.o_player, 1);
        step(1'b0, 3'd0, 1'b0);
        chk("c3_commit_pulse", bus.o_commit, 0);
        chk("c3_commit_col_hold", bus.o_commit_col, 3);
        chk("c3_idle_busy", bus.o_busy, 0);
        exp_counts[3] = 1;
        exp_player    = 1'b1;

        // Fill column 0, then request it again
        for (int i = 0; i < 6; i++) drop(0);
        chk("c0_field", bus.o_piled_count_array[2:0], 6);
        step(1'b1, 3'd0, 1'b0);
        chk("c0_full_nack", bus.o_nack, 1);
        chk("c0_full_ack", bus.o_ack, 0);
        chk("c0_full_busy", bus.o_busy, 0);
        step(1'b0, 3'd0, 1'b0);
        chk("c0_full_player", bus.o_player, exp_player);
        chk("c0_full_array", bus.o_piled_count_array, packed_model());

        // Fill the remaining columns up to 42 pieces
        for (int c = 1; c < 7; c++) begin
            while (exp_counts[c] < 6) begin
                if (c == 6 && exp_counts[c] == 5) chk("pre_full", bus.o_board_full, 0);
                drop(c);
            end
        end
        chk("board_full", bus.o_board_full, 1);
        chk("full_player", bus.o_player, 0);
        chk("full_array", bus.o_piled_count_array, 21'o6666666);
        step(1'b1, 3'd2, 1'b1);
        chk("full_nack", bus.o_nack, 1);
        chk("full_ack", bus.o_ack, 0);
        step(1'b0, 3'd0, 1'b1);
        chk("full_nack_pulse", bus.o_nack, 0);
        chk("full_stays", bus.o_board_full, 1);

        // Reset mid-FALL
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, 1'b0);
        chk("rst2_array", bus.o_piled_count_array, 0);
        step(1'b1, 3'd4, 1'b0);
        chk("mid_ack", bus.o_ack, 1);
        step(1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b1);
        chk("mid_row", bus.o_fall_row, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {bus.o_ack, bus.o_nack, bus.o_busy, bus.o_player,
                                bus.o_fall_valid, bus.o_fall_col, bus.o_fall_row,
                                bus.o_commit, bus.o_commit_col, bus.o_commit_row,
                                bus.o_board_full}, 0);
        chk("mid_rst_array", bus.o_piled_count_array, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b0, 3'd0, 1'b1);
        chk("post_rst_array", bus.o_piled_count_array, 0);
        chk("post_rst_busy", bus.o_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
